// File: rtl/max_msb_stream.sv
// max_msb_stream
//   Streaming max-MSB reducer. Accepts num_beats beats of LANES signed
//   elements over a valid/ready handshake. It reports three results:
//   - the highest set-bit index over all contributing elements
//   - whether any contributing element was nonzero
//   - the (beat, lane) of the first element that reaches that index
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   start                begin a reduction (ignored while busy)
//   num_beats            beats in this reduction, clamped to BEATS_MAX
//   abs_mode             0: negatives count as zero, 1: magnitude counts
//   in_valid / in_ready  beat handshake, in_data lane i at [i*WIDTH +: WIDTH]
//   busy                 reduction in progress
//   done                 one-cycle pulse when results update
//   msb_index            highest set-bit index found
//   any_nonzero          at least one contributing element was nonzero
//   arg_beat / arg_lane  location of the first winning element
//
// state  | meaning
// IDLE   | waiting for start; holds last results
// ACCEPT | taking beats; stage-1 result of each beat folds one cycle later
// DRAIN  | folding the last beat's stage-1 result into the accumulator
// FINISH | copying the accumulator to the outputs, pulsing done
module max_msb_stream #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int BEATS_MAX = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [$clog2(BEATS_MAX+1)-1:0]   num_beats,
    input  logic                             abs_mode,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*WIDTH-1:0]           in_data,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(WIDTH):0]           msb_index,
    output logic                             any_nonzero,
    output logic [$clog2(BEATS_MAX)-1:0]     arg_beat,
    output logic [$clog2(LANES)-1:0]         arg_lane
);
    localparam int NBW  = $clog2(BEATS_MAX+1);
    localparam int IDXW = $clog2(WIDTH) + 1;
    localparam int BW   = $clog2(BEATS_MAX);
    localparam int LW   = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN, FINISH} state_t;

    state_t            state_q, state_d;
    logic [NBW-1:0]    num_beats_q, num_beats_d;
    logic              abs_q, abs_d;
    logic [NBW-1:0]    beat_cnt_q, beat_cnt_d;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_nz_q, s1_nz_d;
    logic [IDXW-1:0]   s1_idx_q, s1_idx_d;
    logic [LW-1:0]     s1_lane_q, s1_lane_d;
    logic [BW-1:0]     s1_beat_q, s1_beat_d;

    logic              acc_nz_q, acc_nz_d;
    logic [IDXW-1:0]   acc_idx_q, acc_idx_d;
    logic [LW-1:0]     acc_lane_q, acc_lane_d;
    logic [BW-1:0]     acc_beat_q, acc_beat_d;

    logic              out_nz_q, out_nz_d;
    logic [IDXW-1:0]   out_idx_q, out_idx_d;
    logic [LW-1:0]     out_lane_q, out_lane_d;
    logic [BW-1:0]     out_beat_q, out_beat_d;
    logic              done_q, done_d;

    logic              accept;
    logic              last_beat;

    // Per-beat reduction results
    logic [WIDTH-1:0]  elem;
    logic [WIDTH:0]    mag;
    logic              e_nz;
    logic [IDXW-1:0]   e_idx;
    logic              ln_nz;
    logic [IDXW-1:0]   ln_idx;
    logic [LW-1:0]     ln_sel;

    function automatic logic [IDXW-1:0] msb_of(input logic [WIDTH:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    // Elements are ranked by {nonzero, index}, so a zero element never beats
    // a nonzero one even though both have index 0. Strict compare keeps the
    // lowest lane on ties.
    always_comb begin
        ln_nz  = 1'b0;
        ln_idx = '0;
        ln_sel = '0;
        elem   = '0;
        mag    = '0;
        e_nz   = 1'b0;
        e_idx  = '0;
        for (int i = 0; i < LANES; i++) begin
            elem = in_data[i*WIDTH +: WIDTH];
            if (elem[WIDTH-1]) begin
                // one extra bit so the most negative value has a magnitude
                mag = abs_q ? ((WIDTH+1)'(0) - {1'b1, elem}) : '0;
            end else begin
                mag = {1'b0, elem};
            end
            e_nz  = |mag;
            e_idx = msb_of(mag);
            if ({e_nz, e_idx} > {ln_nz, ln_idx}) begin
                ln_nz  = e_nz;
                ln_idx = e_idx;
                ln_sel = LW'(i);
            end
        end
    end

    assign accept    = (state_q == ACCEPT) && in_valid;
    assign last_beat = (beat_cnt_q + NBW'(1)) == num_beats_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_beats == '0) ? DRAIN : ACCEPT;
            ACCEPT:  if (accept && last_beat) state_d = DRAIN;
            DRAIN:   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE:    busy = 1'b0;
            ACCEPT:  in_ready = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        num_beats_d = num_beats_q;
        abs_d       = abs_q;
        beat_cnt_d  = beat_cnt_q;
        s1_valid_d  = 1'b0;
        s1_nz_d     = s1_nz_q;
        s1_idx_d    = s1_idx_q;
        s1_lane_d   = s1_lane_q;
        s1_beat_d   = s1_beat_q;
        acc_nz_d    = acc_nz_q;
        acc_idx_d   = acc_idx_q;
        acc_lane_d  = acc_lane_q;
        acc_beat_d  = acc_beat_q;
        out_nz_d    = out_nz_q;
        out_idx_d   = out_idx_q;
        out_lane_d  = out_lane_q;
        out_beat_d  = out_beat_q;
        done_d      = 1'b0;

        if (state_q == IDLE && start) begin
            num_beats_d = (num_beats > NBW'(BEATS_MAX)) ? NBW'(BEATS_MAX) : num_beats;
            abs_d       = abs_mode;
            beat_cnt_d  = '0;
            acc_nz_d    = 1'b0;
            acc_idx_d   = '0;
            acc_lane_d  = '0;
            acc_beat_d  = '0;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_nz_d    = ln_nz;
            s1_idx_d   = ln_idx;
            s1_lane_d  = ln_sel;
            s1_beat_d  = BW'(beat_cnt_q);
            beat_cnt_d = beat_cnt_q + NBW'(1);
        end

        // Strictly greater: ties keep the earlier beat
        if (s1_valid_q && ({s1_nz_q, s1_idx_q} > {acc_nz_q, acc_idx_q})) begin
            acc_nz_d   = s1_nz_q;
            acc_idx_d  = s1_idx_q;
            acc_lane_d = s1_lane_q;
            acc_beat_d = s1_beat_q;
        end

        if (state_q == FINISH) begin
            out_nz_d   = acc_nz_q;
            out_idx_d  = acc_idx_q;
            out_lane_d = acc_lane_q;
            out_beat_d = acc_beat_q;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_beats_q <= '0;
            abs_q       <= 1'b0;
            beat_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_nz_q     <= 1'b0;
            s1_idx_q    <= '0;
            s1_lane_q   <= '0;
            s1_beat_q   <= '0;
            acc_nz_q    <= 1'b0;
            acc_idx_q   <= '0;
            acc_lane_q  <= '0;
            acc_beat_q  <= '0;
            out_nz_q    <= 1'b0;
            out_idx_q   <= '0;
            out_lane_q  <= '0;
            out_beat_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            num_beats_q <= num_beats_d;
            abs_q       <= abs_d;
            beat_cnt_q  <= beat_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_nz_q     <= s1_nz_d;
            s1_idx_q    <= s1_idx_d;
            s1_lane_q   <= s1_lane_d;
            s1_beat_q   <= s1_beat_d;
            acc_nz_q    <= acc_nz_d;
            acc_idx_q   <= acc_idx_d;
            acc_lane_q  <= acc_lane_d;
            acc_beat_q  <= acc_beat_d;
            out_nz_q    <= out_nz_d;
            out_idx_q   <= out_idx_d;
            out_lane_q  <= out_lane_d;
            out_beat_q  <= out_beat_d;
            done_q      <= done_d;
        end
    end

    assign done        = done_q;
    assign msb_index   = out_idx_q;
    assign any_nonzero = out_nz_q;
    assign arg_beat    = out_beat_q;
    assign arg_lane    = out_lane_q;

endmodule

// File: doc/max_msb_stream.md
# max_msb_stream

Streaming, parametrised successor to the single-shot max-MSB finder in the attention path. It reduces a vector of up to BEATS_MAX × LANES signed elements, delivered as beats over a valid/ready handshake, to three results: the highest set-bit index of any element, a nonzero flag, and the (beat, lane) location of the first element reaching that index. A runtime mode selects whether negative elements count by magnitude or are ignored. Softmax and normalisation stages use msb_index as the shift amount for a whole row.

## Interface
- WIDTH, 8, element width in bits (signed two's complement)
- LANES, 4, elements per beat
- BEATS_MAX, 16, maximum beats per reduction
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a reduction; sampled only when busy=0
- num_beats  in  $clog2(BEATS_MAX+1)  beats in this reduction; latched on start
- abs_mode  in  1  0: negatives treated as zero; 1: magnitude used; latched on start
- in_valid  in  1  beat present on in_data
- in_ready  out  1  block accepts a beat
- in_data  in  LANES*WIDTH  packed beat; lane i at bits [i*WIDTH +: WIDTH]
- busy  out  1  reduction in progress
- done  out  1  one-cycle pulse; results valid from this cycle on
- msb_index  out  $clog2(WIDTH)+1  highest set-bit index found
- any_nonzero  out  1  at least one contributing element was nonzero
- arg_beat  out  $clog2(BEATS_MAX)  beat of the winning element
- arg_lane  out  $clog2(LANES)  lane of the winning element

## Operation
- FSM states: IDLE, ACCEPT, DRAIN, FINISH.
- IDLE: busy=0, in_ready=0. start=1 latches num_beats (clamped to BEATS_MAX) and abs_mode, clears the accumulator and beat counter, and moves to ACCEPT. If num_beats=0 it moves to DRAIN instead.
- ACCEPT: busy=1, in_ready=1. A beat is accepted on each edge with in_valid=1. After the num_beats-th acceptance the FSM moves to DRAIN. in_valid gaps of any length are allowed.
- DRAIN: busy=1, in_ready=0. The last beat's lane result is folded into the accumulator. Next state is FINISH.
- FINISH: busy=1, in_ready=0. The accumulator is copied to the output registers, done is registered high, and the FSM returns to IDLE.
- Per-element contribution value v:
  - abs_mode=0: v = x if x>0, else 0.
  - abs_mode=1: v = |x|, computed in WIDTH+1 bits, so -2^(WIDTH-1) gives index WIDTH-1.
- Per-element index is the highest set bit of v. If v=0 the element does not win unless no element is nonzero.
- Stage 1 (registered at the acceptance edge): per-beat maximum index, the lowest winning lane, and the beat number.
- Stage 2 accumulator: replaced only when the beat maximum is strictly greater than the stored maximum. Ties therefore keep the earliest beat, and within a beat the lowest lane.
- All-zero input, or num_beats=0: msb_index=0, any_nonzero=0, arg_beat=0, arg_lane=0.
- Outputs change only in the done cycle and hold until the next done or reset.
- start while busy=1 is ignored. start in a done cycle (busy=0) is accepted.
- in_valid while in_ready=0 is ignored.

## Timing
- Reset values: all outputs 0, state IDLE. This applies at any point, including mid-reduction. An interrupted reduction produces no done and no output change.
- in_ready is 1 from the cycle after the start edge.
- Latency: if the last beat is accepted at edge k, done is 1 in the cycle following edge k+2, and msb_index, any_nonzero, arg_beat and arg_lane update at that same edge k+2.
- num_beats=0 with start at edge s: done follows edge s+2.
- Minimum start-to-start spacing with 1 beat and no gaps is 4 cycles.
- Throughput is one beat per cycle while in_valid is held high.

## Test plan
- WIDTH=8, LANES=4, abs_mode=0, 1 beat {3,64,63,16} -> msb_index=6, any_nonzero=1, arg_lane=1, arg_beat=0; done exactly 2 edges after acceptance.
- 1 beat {-128,64,16,32}:
  - abs_mode=1 -> msb_index=7, arg_lane=0.
  - repeated with abs_mode=0 -> msb_index=6, arg_lane=1.
- num_beats=3, abs_mode=0, in_valid toggled every other cycle, beats {1,2,3,4}, {0,0,0,0}, {0,-3,8,0} -> msb_index=3, arg_beat=2, arg_lane=2; in_ready stays 1 through the gaps.
- Ties: num_beats=2, beats {0,5,4,0}, {6,0,0,0} -> msb_index=2, arg_beat=0, arg_lane=1.
- Zero cases:
  - all-zero 2 beats -> msb_index=0, any_nonzero=0.
  - num_beats=0 -> no beats accepted; done after 2 edges with zero results.
  - abs_mode=0 with {-1,-2,-3,-4} -> any_nonzero=0.
- Control:
  - reset after 1 of 3 beats -> in_ready=0, busy=0, outputs 0, no done; a following 1-beat reduction completes normally.
  - start asserted while busy -> ignored.
  - start asserted in the done cycle -> new reduction begins, in_ready=1 the next cycle.
